ctrl_pipeline: RTL and testbench

//  Carries the decoded control bundle from ID through EX, MEM and WB, and owns pipeline flow control.

---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/ctrl_hazard_detect.sv | 72 +++++++
 rtl/ctrl_pipeline.sv | 191 +++++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ctrl_pkg: control bundle type, field indices and forwarding codes  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package ctrl_pkg;

    typedef struct packed {
        logic reg_wren;
        logic mem_to_reg;
        logic mem_wr;
        logic alu_src;
        logic reg_dst;
        logic branch;
    } ctrl_t;

    localparam int CTRL_W          = 6;
    localparam int CTRL_REG_WREN   = 5;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_MEM_WR     = 3;
    localparam int CTRL_ALU_SRC    = 2;
    localparam int CTRL_REG_DST    = 1;
    localparam int CTRL_BRANCH     = 0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int REG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/ctrl_hazard_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ctrl_hazard_detect: load-use, taken-branch and EX forwarding logic |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ctrl_hazard_detect
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_valid,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_branch,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_branch_taken,
    input  logic                  mem_valid,
    input  logic                  mem_reg_wren,
    input  logic                  mem_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_reg_wren,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  luse,
    output logic                  take,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(REG_ZERO);

    logic ex_load_live;
    logic mem_can_fwd;
    logic wb_can_fwd;

    assign ex_load_live = ex_valid & ex_mem_to_reg & (ex_rd != ZERO_REG);

    assign luse = ex_load_live & id_valid &
                  ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

    assign take = ex_valid & ex_branch & ex_branch_taken;

    // A load in MEM has no data yet, so it is never a forwarding source.
    assign mem_can_fwd = mem_valid & mem_reg_wren & ~mem_mem_to_reg & (mem_rd != ZERO_REG);
    assign wb_can_fwd  = wb_valid & wb_reg_wren & (wb_rd != ZERO_REG);

    always_comb begin
        fwd_a = FWD_RF;
        if (wb_can_fwd && (wb_rd == ex_rs)) begin
            fwd_a = FWD_WB;
        end
        if (mem_can_fwd && (mem_rd == ex_rs)) begin
            fwd_a = FWD_MEM;
        end

        fwd_b = FWD_RF;
        if (wb_can_fwd && (wb_rd == ex_rt)) begin
            fwd_b = FWD_WB;
        end
        if (mem_can_fwd && (mem_rd == ex_rt)) begin
            fwd_b = FWD_MEM;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ctrl_pipeline: ID->EX->MEM->WB control bundle pipe, flow control,  |
// | forwarding selects and saturating stall/flush counters.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [5:0]            id_ctrl,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    input  logic                  cnt_clr,
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic                  ex_valid,
    output logic [5:0]            ex_ctrl,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_valid,
    output logic [5:0]            mem_ctrl,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_valid,
    output logic [5:0]            wb_ctrl,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic                  ex_valid_q,  ex_valid_d;
    ctrl_t                 ex_ctrl_q,   ex_ctrl_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,     ex_rd_d;
    logic [REG_ADDR_W-1:0] ex_rs_q,     ex_rs_d;
    logic [REG_ADDR_W-1:0] ex_rt_q,     ex_rt_d;
    logic                  mem_valid_q, mem_valid_d;
    ctrl_t                 mem_ctrl_q,  mem_ctrl_d;
    logic [REG_ADDR_W-1:0] mem_rd_q,    mem_rd_d;
    logic                  wb_valid_q,  wb_valid_d;
    ctrl_t                 wb_ctrl_q,   wb_ctrl_d;
    logic [REG_ADDR_W-1:0] wb_rd_q,     wb_rd_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic luse;
    logic take;

    ctrl_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_valid        (ex_valid_q),
        .ex_mem_to_reg   (ex_ctrl_q.mem_to_reg),
        .ex_branch       (ex_ctrl_q.branch),
        .ex_rd           (ex_rd_q),
        .ex_rs           (ex_rs_q),
        .ex_rt           (ex_rt_q),
        .ex_branch_taken (ex_branch_taken),
        .mem_valid       (mem_valid_q),
        .mem_reg_wren    (mem_ctrl_q.reg_wren),
        .mem_mem_to_reg  (mem_ctrl_q.mem_to_reg),
        .mem_rd          (mem_rd_q),
        .wb_valid        (wb_valid_q),
        .wb_reg_wren     (wb_ctrl_q.reg_wren),
        .wb_rd           (wb_rd_q),
        .luse            (luse),
        .take            (take),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_ctrl_d   = ex_ctrl_q;
        ex_rd_d     = ex_rd_q;
        ex_rs_d     = ex_rs_q;
        ex_rt_d     = ex_rt_q;
        mem_valid_d = mem_valid_q;
        mem_ctrl_d  = mem_ctrl_q;
        mem_rd_d    = mem_rd_q;
        wb_valid_d  = wb_valid_q;
        wb_ctrl_d   = wb_ctrl_q;
        wb_rd_d     = wb_rd_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!mem_busy) begin
            wb_valid_d  = mem_valid_q;
            wb_ctrl_d   = mem_ctrl_q;
            wb_rd_d     = mem_rd_q;
            mem_valid_d = ex_valid_q;
            mem_ctrl_d  = ex_ctrl_q;
            mem_rd_d    = ex_rd_q;

            // Bubbles carry an all-zero bundle so they can never write.
            if (id_valid && !luse && !take) begin
                ex_valid_d = 1'b1;
                ex_ctrl_d  = ctrl_t'(id_ctrl);
                ex_rd_d    = id_rd;
                ex_rs_d    = id_rs;
                ex_rt_d    = id_rt;
            end else begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
                ex_rd_d    = '0;
                ex_rs_d    = '0;
                ex_rt_d    = '0;
            end

            if (take) begin
                if (flush_cnt_q != '1) begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end else if (luse) begin
                if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
        end

        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rd_q     <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= '0;
            wb_rd_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            mem_valid_q <= mem_valid_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_rd_q    <= mem_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_rd_q     <= wb_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // A flush overrides a coincident load-use stall; a memory stall freezes everything.
    assign stall_if_id = mem_busy | (luse & ~take);
    assign flush_if_id = ~mem_busy & take;

    assign ex_valid  = ex_valid_q;
    assign ex_ctrl   = ex_ctrl_q;
    assign ex_rd     = ex_rd_q;
    assign mem_valid = mem_valid_q;
    assign mem_ctrl  = mem_ctrl_q;
    assign mem_rd    = mem_rd_q;
    assign wb_valid  = wb_valid_q;
    assign wb_ctrl   = wb_ctrl_q;
    assign wb_rd     = wb_rd_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for ctrl_pipeline: behavioural pipeline model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_ctrl_pipeline;

    localparam logic [5:0] C_LW   = 6'b110100;
    localparam logic [5:0] C_ADD  = 6'b100010;
    localparam logic [5:0] C_BEQ  = 6'b000001;
    localparam logic [5:0] C_LDBR = 6'b110101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [5:0] id_ctrl = '0;
    logic [3:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic       ex_branch_taken = 1'b0, mem_busy = 1'b0, cnt_clr = 1'b0;

    logic        stall_if_id, flush_if_id, ex_valid, mem_valid, wb_valid;
    logic [5:0]  ex_ctrl, mem_ctrl, wb_ctrl;
    logic [3:0]  ex_rd, mem_rd, wb_rd;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall_if_id, s_flush_if_id, s_ex_valid, s_mem_valid, s_wb_valid;
    logic [5:0]  s_ex_ctrl, s_mem_ctrl, s_wb_ctrl;
    logic [3:0]  s_ex_rd, s_mem_rd, s_wb_rd;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ctrl_pipeline #(.REG_ADDR_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy: exercises saturation within a short run.
    ctrl_pipeline #(.REG_ADDR_W(4), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .stall_if_id(s_stall_if_id), .flush_if_id(s_flush_if_id),
        .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl), .ex_rd(s_ex_rd),
        .mem_valid(s_mem_valid), .mem_ctrl(s_mem_ctrl), .mem_rd(s_mem_rd),
        .wb_valid(s_wb_valid), .wb_ctrl(s_wb_ctrl), .wb_rd(s_wb_rd),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       v;
        logic [5:0] c;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
    } slot_t;

    slot_t m_ex, m_mem, m_wb;
    int m_sc, m_fc, m_sc4, m_fc4;

    function automatic int sat_inc(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    function automatic logic m_luse();
        return m_ex.v && m_ex.c[4] && (m_ex.rd != 0) && id_valid &&
               ((id_uses_rs && id_rs == m_ex.rd) || (id_uses_rt && id_rt == m_ex.rd));
    endfunction

    function automatic logic m_take();
        return m_ex.v && m_ex.c[0] && ex_branch_taken;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [3:0] r);
        if (m_mem.v && m_mem.c[5] && !m_mem.c[4] && m_mem.rd != 0 && m_mem.rd == r) return 2'b10;
        if (m_wb.v && m_wb.c[5] && m_wb.rd != 0 && m_wb.rd == r) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex <= '0; m_mem <= '0; m_wb <= '0;
            m_sc <= 0; m_fc <= 0; m_sc4 <= 0; m_fc4 <= 0;
        end else if (!mem_busy) begin
            if (cnt_clr) begin
                m_sc <= 0; m_fc <= 0; m_sc4 <= 0; m_fc4 <= 0;
            end else if (m_take()) begin
                m_fc <= sat_inc(m_fc, 65535); m_fc4 <= sat_inc(m_fc4, 15);
            end else if (m_luse()) begin
                m_sc <= sat_inc(m_sc, 65535); m_sc4 <= sat_inc(m_sc4, 15);
            end
            m_wb  <= m_mem;
            m_mem <= m_ex;
            if (id_valid && !m_luse() && !m_take())
                m_ex <= '{v: 1'b1, c: id_ctrl, rd: id_rd, rs: id_rs, rt: id_rt};
            else
                m_ex <= '0;
        end
    end

    always @(negedge clk) begin
        chk("ex_valid", ex_valid, m_ex.v);
        chk("ex_ctrl", ex_ctrl, m_ex.c);
        if (m_ex.v) chk("ex_rd", ex_rd, m_ex.rd);
        chk("mem_valid", mem_valid, m_mem.v);
        chk("mem_ctrl", mem_ctrl, m_mem.c);
        if (m_mem.v) chk("mem_rd", mem_rd, m_mem.rd);
        chk("wb_valid", wb_valid, m_wb.v);
        chk("wb_ctrl", wb_ctrl, m_wb.c);
        if (m_wb.v) chk("wb_rd", wb_rd, m_wb.rd);
        chk("stall_if_id", stall_if_id, mem_busy || (m_luse() && !m_take()));
        chk("flush_if_id", flush_if_id, !mem_busy && m_take());
        if (m_ex.v) begin
            chk("fwd_a", fwd_a, m_fwd(m_ex.rs));
            chk("fwd_b", fwd_b, m_fwd(m_ex.rt));
        end
        chk("stall_cnt", stall_cnt, m_sc);
        chk("flush_cnt", flush_cnt, m_fc);
        chk("s_stall_cnt", s_stall_cnt, m_sc4);
        chk("s_flush_cnt", s_flush_cnt, m_fc4);
        chk("s_ex_valid", s_ex_valid, m_ex.v);
        chk("s_stall_if_id", s_stall_if_id, mem_busy || (m_luse() && !m_take()));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic ins(input logic v, input logic [5:0] c, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [3:0] rd,
                       input logic urs, input logic urt);
        id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt;
    endtask

    task automatic nop();
        ins(1'b0, 6'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_fwd_a", fwd_a, 0);
        rst_n = 1'b1;
        cyc();

        // Load then use
        ins(1, C_LW, 4'd1, 4'd0, 4'd3, 1, 0); cyc();
        ins(1, C_ADD, 4'd3, 4'd5, 4'd4, 1, 1);
        at_neg(); chk("lu_stall", stall_if_id, 1); chk("lu_noflush", flush_if_id, 0);
        cyc();
        at_neg(); chk("lu_bubble", ex_valid, 0); chk("lu_cnt", stall_cnt, 1); chk("lu_release", stall_if_id, 0);
        cyc(); nop();
        at_neg(); chk("lu_ex_rd", ex_rd, 4); chk("lu_fwd_a", fwd_a, 2'b01); chk("lu_fwd_b", fwd_b, 2'b00);
        cyc();

        // ALU then use
        ins(1, C_ADD, 4'd7, 4'd8, 4'd2, 1, 1); cyc();
        ins(1, C_ADD, 4'd2, 4'd2, 4'd6, 1, 1);
        at_neg(); chk("alu_nostall", stall_if_id, 0);
        cyc();
        ins(1, C_ADD, 4'd2, 4'd0, 4'd9, 1, 1);
        at_neg(); chk("alu_fwd_a", fwd_a, 2'b10); chk("alu_fwd_b", fwd_b, 2'b10);
        cyc(); nop();
        at_neg(); chk("alu_wb_fwd_a", fwd_a, 2'b01); chk("alu_r0_fwd_b", fwd_b, 2'b00);
        cyc();

        // Taken branch coinciding with load-use
        ins(1, C_LDBR, 4'd1, 4'd0, 4'd3, 1, 0); cyc();
        ins(1, C_ADD, 4'd3, 4'd3, 4'd4, 1, 1); ex_branch_taken = 1'b1;
        at_neg(); chk("bl_flush", flush_if_id, 1); chk("bl_stall", stall_if_id, 0);
        cyc(); ex_branch_taken = 1'b0; nop();
        at_neg(); chk("bl_flush_cnt", flush_cnt, 1); chk("bl_stall_cnt", stall_cnt, 1);
        chk("bl_bubble", ex_valid, 0); chk("bl_br_mem", mem_ctrl, C_LDBR);
        cyc();

        // Memory stall over a taken branch
        ins(1, C_BEQ, 4'd1, 4'd2, 4'd0, 1, 1); cyc();
        ins(1, C_ADD, 4'd4, 4'd5, 4'd6, 1, 1); ex_branch_taken = 1'b1; mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg(); chk("busy_flush", flush_if_id, 0); chk("busy_stall", stall_if_id, 1);
            chk("busy_ex_ctrl", ex_ctrl, C_BEQ);
            cyc();
        end
        mem_busy = 1'b0;
        at_neg(); chk("busy_end_flush", flush_if_id, 1);
        cyc(); ex_branch_taken = 1'b0; nop();
        at_neg(); chk("busy_flush_cnt", flush_cnt, 2); chk("busy_br_mem", mem_ctrl, C_BEQ);
        cyc();

        // Destination R0
        ins(1, C_LW, 4'd1, 4'd0, 4'd0, 1, 0); cyc();
        ins(1, C_ADD, 4'd0, 4'd0, 4'd7, 1, 1);
        at_neg(); chk("r0_nostall", stall_if_id, 0);
        cyc();
        ins(1, C_ADD, 4'd0, 4'd0, 4'd8, 1, 1);
        at_neg(); chk("r0_fwd_mem", fwd_a, 2'b00);
        cyc();
        at_neg(); chk("r0_fwd_wb", fwd_a, 2'b00); chk("r0_cnt", stall_cnt, 1);

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            ins(1, C_LW, 4'd1, 4'd0, 4'd3, 1, 0); cyc();
            ins(1, C_ADD, 4'd3, 4'd5, 4'd4, 1, 1); cyc();
        end
        nop();
        at_neg(); chk("sat_cnt4", s_stall_cnt, 4'hF); chk("cnt16", stall_cnt, 21);
        cyc();

        // Clear beats a coincident increment
        ins(1, C_LW, 4'd1, 4'd0, 4'd3, 1, 0); cyc();
        ins(1, C_ADD, 4'd3, 4'd5, 4'd4, 1, 1); cnt_clr = 1'b1; cyc();
        cnt_clr = 1'b0; nop();
        at_neg(); chk("clr_stall", stall_cnt, 0); chk("clr_flush", flush_cnt, 0); chk("clr_s_stall", s_stall_cnt, 0);
        cyc();

        // Reset mid-stream
        ins(1, C_LW, 4'd1, 4'd0, 4'd3, 1, 0); cyc();
        ins(1, C_ADD, 4'd3, 4'd5, 4'd4, 1, 1); cyc();
        ins(1, C_ADD, 4'd1, 4'd2, 4'd10, 1, 1); cyc();
        ins(1, C_ADD, 4'd1, 4'd2, 4'd11, 1, 1); cyc();
        ins(1, C_ADD, 4'd1, 4'd2, 4'd12, 1, 1); cyc();
        nop();
        at_neg(); chk("pre_rst_wb", wb_valid, 1); chk("pre_rst_cnt", stall_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ex_valid", ex_valid, 0); chk("mrst_mem_valid", mem_valid, 0);
        chk("mrst_wb_valid", wb_valid, 0); chk("mrst_wb_ctrl", wb_ctrl, 0);
        chk("mrst_stall_cnt", stall_cnt, 0);
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
